// File: rtl/fprop_sequencer_pkg.sv
// Shared types and default sizes for the forward-propagation sequencer.
package fprop_pkg;

  typedef enum logic [2:0] {
    IDLE,
    L0_ISS,
    L0_RUN,
    ACT0,
    L1_ISS,
    L1_RUN,
    ACT1,
    DONE
  } seq_state_t;

  localparam int L0_ROWS_DEF = 784;
  localparam int L1_ROWS_DEF = 128;
  localparam int CNT_W_DEF   = 10;

endpackage

// File: rtl/fprop_sequencer_row_counter.sv
// Weight-row index counter shared by both layers; returns to 0 after the last row.
module row_counter #(
  parameter int CNT_W = 10
) (
  input  logic             clka,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] idx,
  output logic             last
);

  logic [CNT_W-1:0] idx_q, idx_d;

  assign last = (idx_q == limit);
  assign idx  = idx_q;

  // Wrapping to 0 on the last row keeps mac_row at 0 whenever mac_en is low.
  always_comb begin
    idx_d = idx_q;
    if (load)
      idx_d = '0;
    else if (en)
      idx_d = last ? '0 : idx_q + 1'b1;
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst)
      idx_q <= '0;
    else
      idx_q <= idx_d;
  end

endmodule

// File: rtl/fprop_sequencer.sv
// Two-layer forward-propagation control FSM.
// Optional feature: define SEQ_PERF_EN to add the perf_cycles busy-cycle counter.
module fprop_sequencer
  import fprop_pkg::*;
#(
  parameter int L0_ROWS = L0_ROWS_DEF,
  parameter int L1_ROWS = L1_ROWS_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clka,
  input  logic             rst,
  input  logic             img_valid,
  output logic             img_ready,
  output logic             start_0,
  output logic             start_1,
  output logic             acc_clr,
  output logic             mac_en,
  output logic             mac_layer,
  output logic [CNT_W-1:0] mac_row,
  output logic             act_start,
  input  logic             act_done,
  output logic             result_valid,
  input  logic             result_ready,
`ifdef SEQ_PERF_EN
  output logic [31:0]      perf_cycles,
`endif
  output logic             busy
);

  seq_state_t       state_q;
  logic             img_ready_q, start_0_q, start_1_q, acc_clr_q;
  logic             mac_en_q, mac_layer_q, act_start_q, result_valid_q;
  logic             row_load, row_en, row_last;
  logic [CNT_W-1:0] row_limit, row_idx;

  assign row_load  = (state_q == L0_ISS) || (state_q == L1_ISS);
  assign row_en    = (state_q == L0_RUN) || (state_q == L1_RUN);
  assign row_limit = (state_q == L1_RUN) ? CNT_W'(L1_ROWS - 1) : CNT_W'(L0_ROWS - 1);

  row_counter #(.CNT_W(CNT_W)) u_row_counter (
    .clka  (clka),
    .rst   (rst),
    .load  (row_load),
    .en    (row_en),
    .limit (row_limit),
    .idx   (row_idx),
    .last  (row_last)
  );

  // Outputs are registered on entry to the state in which they must be visible.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      img_ready_q    <= 1'b1;
      start_0_q      <= 1'b0;
      start_1_q      <= 1'b0;
      acc_clr_q      <= 1'b0;
      mac_en_q       <= 1'b0;
      mac_layer_q    <= 1'b0;
      act_start_q    <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      start_0_q   <= 1'b0;
      start_1_q   <= 1'b0;
      acc_clr_q   <= 1'b0;
      act_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (img_valid) begin
            state_q     <= L0_ISS;
            img_ready_q <= 1'b0;
            start_0_q   <= 1'b1;
            acc_clr_q   <= 1'b1;
          end
        end
        L0_ISS: begin
          state_q     <= L0_RUN;
          mac_en_q    <= 1'b1;
          mac_layer_q <= 1'b0;
        end
        L0_RUN: begin
          if (row_last) begin
            state_q     <= ACT0;
            mac_en_q    <= 1'b0;
            act_start_q <= 1'b1;
          end
        end
        ACT0: begin
          // act_done coinciding with the act_start cycle belongs to no request.
          if (act_done && !act_start_q) begin
            state_q   <= L1_ISS;
            start_1_q <= 1'b1;
            acc_clr_q <= 1'b1;
          end
        end
        L1_ISS: begin
          state_q     <= L1_RUN;
          mac_en_q    <= 1'b1;
          mac_layer_q <= 1'b1;
        end
        L1_RUN: begin
          if (row_last) begin
            state_q     <= ACT1;
            mac_en_q    <= 1'b0;
            mac_layer_q <= 1'b0;
            act_start_q <= 1'b1;
          end
        end
        ACT1: begin
          if (act_done && !act_start_q) begin
            state_q        <= DONE;
            result_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (result_ready) begin
            state_q        <= IDLE;
            result_valid_q <= 1'b0;
            img_ready_q    <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          img_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign img_ready    = img_ready_q;
  assign start_0      = start_0_q;
  assign start_1      = start_1_q;
  assign acc_clr      = acc_clr_q;
  assign mac_en       = mac_en_q;
  assign mac_layer    = mac_layer_q;
  assign mac_row      = row_idx;
  assign act_start    = act_start_q;
  assign result_valid = result_valid_q;
  assign busy         = (state_q != IDLE);

`ifdef SEQ_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clka or posedge rst) begin
    if (rst)
      perf_q <= '0;
    else if (state_q == IDLE && img_valid)
      perf_q <= '0;
    else if (state_q != IDLE && state_q != DONE && perf_q != '1)
      perf_q <= perf_q + 32'd1;
  end

  assign perf_cycles = perf_q;
`endif

endmodule
